// File: rtl/my_seq_shifter_if.sv
// Handshake and data bundle between the control unit (master) and the multi-cycle shifter (slave).
interface my_seq_shifter_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
);
  logic               start;
  logic [2:0]         mode;
  logic [WIDTH-1:0]   op1;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   out;
  logic               cout;
  logic               ovf;

  modport master (
    output start, mode, op1, shamt,
    input  busy, done, out, cout, ovf
  );

  modport slave (
    input  start, mode, op1, shamt,
    output busy, done, out, cout, ovf
  );
endinterface

// File: rtl/my_seq_shifter.sv
// Multi-cycle shift/rotate unit: one bit position per clock, start/busy/done handshake.
//   state | meaning
//   IDLE  | waiting for start; final results held
//   SHIFT | one 1-bit step per clock, busy=1
//   DONE  | one-cycle done pulse; a new start is accepted here too
module my_seq_shifter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input logic             clk,
  input logic             rst_n,
  my_seq_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] M_LSL = 3'b000;
  localparam logic [2:0] M_LSR = 3'b001;
  localparam logic [2:0] M_ASL = 3'b010;
  localparam logic [2:0] M_ASR = 3'b011;
  localparam logic [2:0] M_ROL = 3'b100;
  localparam logic [2:0] M_ROR = 3'b101;

  state_t             state, state_n;
  logic [WIDTH-1:0]   out_q, out_n;
  logic               cout_q, cout_n;
  logic               ovf_q, ovf_n;
  logic [SHAMT_W-1:0] count_q, count_n;
  logic [2:0]         mode_q, mode_n;
  logic               reserved;

  assign reserved = bus.mode[2] & bus.mode[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      mode_q  <= '0;
    end else begin
      state   <= state_n;
      out_q   <= out_n;
      cout_q  <= cout_n;
      ovf_q   <= ovf_n;
      count_q <= count_n;
      mode_q  <= mode_n;
    end
  end

  always_comb begin
    state_n = state;
    out_n   = out_q;
    cout_n  = cout_q;
    ovf_n   = ovf_q;
    count_n = count_q;
    mode_n  = mode_q;
    unique case (state)
      SHIFT: begin
        count_n = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) state_n = DONE;
        case (mode_q)
          M_LSL, M_ASL: begin
            out_n  = {out_q[WIDTH-2:0], 1'b0};
            cout_n = out_q[WIDTH-1];
            // ovf is sticky: any sign change along the way overflows the whole operation
            if (mode_q == M_ASL && out_q[WIDTH-1] != out_q[WIDTH-2]) ovf_n = 1'b1;
          end
          M_LSR: begin
            out_n  = {1'b0, out_q[WIDTH-1:1]};
            cout_n = out_q[0];
          end
          M_ASR: begin
            out_n  = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
            cout_n = out_q[0];
          end
          M_ROL: begin
            out_n  = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
            cout_n = out_q[WIDTH-1];
          end
          M_ROR: begin
            out_n  = {out_q[0], out_q[WIDTH-1:1]};
            cout_n = out_q[0];
          end
          default: ;
        endcase
      end
      default: begin
        if (bus.start) begin
          out_n   = bus.op1;
          mode_n  = bus.mode;
          cout_n  = 1'b0;
          ovf_n   = 1'b0;
          count_n = bus.shamt;
          state_n = (bus.shamt != '0 && !reserved) ? SHIFT : DONE;
        end else begin
          state_n = IDLE;
        end
      end
    endcase
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.out  = out_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_my_seq_shifter.sv
// Scoreboard bench for my_seq_shifter: 8-bit and 16-bit instances, directed plus random operations.
`timescale 1ns/1ps
module tb_my_seq_shifter;

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q8[$];
  exp_t q16[$];

  my_seq_shifter_if #(.WIDTH(8),  .SHAMT_W(3)) b8 ();
  my_seq_shifter_if #(.WIDTH(16), .SHAMT_W(4)) b16 ();

  my_seq_shifter #(.WIDTH(8),  .SHAMT_W(3)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  my_seq_shifter #(.WIDTH(16), .SHAMT_W(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // Whole-operation reference: shift by n in one go using plain arithmetic.
  function automatic void model(input int w, input logic [2:0] m, input logic [15:0] op, input int n,
                                output logic [15:0] res, output logic c, output logic v);
    logic [31:0] mask, x, r, top;
    logic signed [31:0] sx;
    mask = (32'd1 << w) - 1;
    x = {16'd0, op} & mask;
    r = x; c = 1'b0; v = 1'b0;
    case (m)
      3'd0, 3'd2: begin
        r = (x << n) & mask;
        if (n > 0) c = x[w-n];
        if (m == 3'd2) begin
          top = x >> (w - 1 - n);
          v = !(top == 0 || top == ((32'd1 << (n + 1)) - 1));
        end
      end
      3'd1: begin
        r = x >> n;
        if (n > 0) c = x[n-1];
      end
      3'd3: begin
        sx = x[w-1] ? $signed(x | ~mask) : $signed(x);
        r = (sx >>> n) & mask;
        if (n > 0) c = x[n-1];
      end
      3'd4: begin
        r = ((x << n) | (x >> (w - n))) & mask;
        if (n > 0) c = r[0];
      end
      3'd5: begin
        r = ((x >> n) | (x << (w - n))) & mask;
        if (n > 0) c = r[w-1];
      end
      default: ;
    endcase
    res = r[15:0];
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) b16.start = v; else b8.start = v;
  endtask

  // Caller is positioned at a negedge; returns at the negedge of the done cycle.
  task automatic do_op(input bit sel, input logic [2:0] m, input logic [15:0] op, input int n, input bit glitch);
    exp_t e;
    int   eff;
    logic bsy;
    model(sel ? 16 : 8, m, op, n, e.res, e.cout, e.ovf);
    eff = (n == 0 || (m[2] & m[1])) ? 0 : n;
    e.done_cyc = cyc + eff + 1;
    if (sel) begin
      b16.mode = m; b16.op1 = op; b16.shamt = n[3:0]; b16.start = 1'b1; q16.push_back(e);
    end else begin
      b8.mode = m; b8.op1 = op[7:0]; b8.shamt = n[2:0]; b8.start = 1'b1; q8.push_back(e);
    end
    for (int i = 1; i <= eff + 1; i++) begin
      @(negedge clk);
      set_start(sel, 1'b0);
      if (glitch && i == 2 && eff >= 2) begin
        if (sel) begin
          b16.mode = 3'($urandom_range(0, 7)); b16.op1 = 16'($urandom); b16.shamt = 4'($urandom);
        end else begin
          b8.mode = 3'($urandom_range(0, 7)); b8.op1 = 8'($urandom); b8.shamt = 3'($urandom);
        end
        set_start(sel, 1'b1);
      end
      bsy = sel ? b16.busy : b8.busy;
      chk(sel ? "busy16" : "busy8", bsy, (i <= eff) ? 1 : 0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && b8.done) begin
      if (q8.size() == 0) chk("done8_unexpected", 1, 0);
      else begin
        e = q8.pop_front();
        chk("out8", b8.out, e.res);
        chk("cout8", b8.cout, e.cout);
        chk("ovf8", b8.ovf, e.ovf);
        chk("lat8", cyc, e.done_cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && b16.done) begin
      if (q16.size() == 0) chk("done16_unexpected", 1, 0);
      else begin
        e = q16.pop_front();
        chk("out16", b16.out, e.res);
        chk("cout16", b16.cout, e.cout);
        chk("ovf16", b16.ovf, e.ovf);
        chk("lat16", cyc, e.done_cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sel;
    int n;
    b8.start = 0;  b8.mode = 0;  b8.op1 = 0;  b8.shamt = 0;
    b16.start = 0; b16.mode = 0; b16.op1 = 0; b16.shamt = 0;
    repeat (3) @(negedge clk);
    chk("rst_out8", b8.out, 0);
    chk("rst_busy8", b8.busy, 0);
    chk("rst_done8", b8.done, 0);
    chk("rst_cout8", b8.cout, 0);
    chk("rst_ovf8", b8.ovf, 0);
    chk("rst_out16", b16.out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(0, 3'b010, 16'h0F, 1, 0); @(negedge clk);
    do_op(0, 3'b010, 16'h01, 1, 0); @(negedge clk);
    do_op(0, 3'b001, 16'h81, 3, 0); @(negedge clk);
    do_op(0, 3'b011, 16'h90, 2, 0); @(negedge clk);
    do_op(0, 3'b100, 16'h81, 1, 0);
    do_op(0, 3'b101, 16'h01, 7, 0); @(negedge clk);
    do_op(0, 3'b010, 16'h40, 1, 0); @(negedge clk);
    do_op(0, 3'b010, 16'hC0, 1, 0); @(negedge clk);
    do_op(0, 3'b000, 16'hAB, 0, 0); @(negedge clk);
    do_op(0, 3'b110, 16'h5A, 3, 0); @(negedge clk);
    do_op(0, 3'b001, 16'hA5, 6, 1); @(negedge clk);

    // reset in cycle 2 of a 5-step LSL: aborted with no done
    b8.mode = 3'b000; b8.op1 = 8'hFF; b8.shamt = 3'd5; b8.start = 1'b1;
    @(negedge clk); b8.start = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("abort_out8", b8.out, 0);
    chk("abort_busy8", b8.busy, 0);
    chk("abort_done8", b8.done, 0);
    chk("abort_cout8", b8.cout, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(negedge clk);
    do_op(0, 3'b000, 16'h33, 5, 0); @(negedge clk);

    do_op(1, 3'b000, 16'h8001, 15, 0); @(negedge clk);
    do_op(1, 3'b011, 16'h8421, 9, 1); @(negedge clk);

    for (int k = 0; k < 60; k++) begin
      sel = 1'($urandom);
      n = $urandom_range(0, sel ? 15 : 7);
      do_op(sel, 3'($urandom_range(0, 7)), 16'($urandom), n, 1'($urandom));
      if ($urandom_range(0, 2) != 0) @(negedge clk);
    end

    for (int i = 0; i < 50 && (q8.size() + q16.size()) != 0; i++) @(negedge clk);
    chk("drain", q8.size() + q16.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
